// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encoding and default sizing.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } arb_state_e;

    localparam int ARB_N        = 5;
    localparam int ARB_IDW      = 3;
    localparam int ARB_MAX_HOLD = 8;

endpackage

// File: rtl/rr_mod_ptr.sv
// Round-robin pointer: mod-N register that loads (load_val + 1) mod N when load_en is high.
module rr_mod_ptr
    import arb_pkg::*;
#(
    parameter int N = ARB_N,
    parameter int W = ARB_IDW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Next pointer: one past the loaded index, wrapping N-1 back to 0.
    always_comb begin
        value_d = value_q;
        if (load_en) begin
            value_d = (load_val == W'(N - 1)) ? '0 : load_val + W'(1);
        end
    end

    // Pointer register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value_q <= '0;
        else        value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/rr5_arbiter.sv
// Round-robin arbiter for N requesters with registered one-hot grant.
// Optional grant timeout compiled in with macro RR5_ARBITER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate on req and load the grant on the same edge
// GRANT | owner holds gnt until rel, its req drops, or hold timeout
// GAP   | one dead cycle, gnt=0, before returning to IDLE
module rr5_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int MAX_HOLD = ARB_MAX_HOLD,
    parameter int IDW      = ARB_IDW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           rel,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    if ((2 ** IDW) < N) begin : g_idw_chk
        $error("rr5_arbiter: IDW too narrow for N");
    end
    if (MAX_HOLD < 2) begin : g_hold_chk
        $error("rr5_arbiter: MAX_HOLD must be at least 2");
    end

    arb_state_e     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           busy_q, busy_d;
    logic           ptr_load;
    logic [IDW-1:0] ptr_val;
    logic [IDW:0]   cand;
    logic [IDW-1:0] win_idx;
    logic           win_found;
    logic           tmo_hit;

    rr_mod_ptr #(
        .N (N),
        .W (IDW)
    ) u_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (ptr_load),
        .load_val (gnt_id_q),
        .value    (ptr_val)
    );

    // Winner search: first set req bit starting at ptr, wrapping N-1 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_val} + (IDW + 1)'(i);
            if (cand >= (IDW + 1)'(N)) cand = cand - (IDW + 1)'(N);
            if (!win_found && req[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

`ifdef RR5_ARBITER_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;

    assign tmo_hit   = (state_q == GRANT) && (hold_q == HW'(MAX_HOLD - 1));
    assign timeout_d = tmo_hit && !rel && req[gnt_id_q];

    // Hold counter: zero outside GRANT, so it is clear on entry; saturates at MAX_HOLD-1.
    always_comb begin
        hold_d = '0;
        if (state_q == GRANT) begin
            hold_d = (hold_q == HW'(MAX_HOLD - 1)) ? hold_q : hold_q + HW'(1);
        end
    end

    // Hold counter and timeout pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        busy_d   = busy_q;
        ptr_load = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (win_found) begin
                    state_d        = GRANT;
                    gnt_d[win_idx] = 1'b1;
                    gnt_id_d       = win_idx;
                    busy_d         = 1'b1;
                end
            end
            GRANT: begin
                if (rel || !req[gnt_id_q] || tmo_hit) begin
                    state_d  = GAP;
                    gnt_d    = '0;
                    busy_d   = 1'b0;
                    ptr_load = 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // FSM and grant registers; reset drops the grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_rr5_arbiter.sv
// Directed bench for rr5_arbiter with a queue of expected per-cycle outputs.
module tb_rr5_arbiter;

    logic       clk;
    logic       rst_n;
    logic [4:0] req;
    logic       rel;
    logic [4:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        logic [4:0] gnt;
        logic [2:0] id;
        logic       busy;
        logic       tmo;
    } exp_t;

    exp_t sb[$];

    rr5_arbiter #(
        .N        (5),
        .MAX_HOLD (8),
        .IDW      (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive inputs, queue the expected outputs after the next edge, then compare.
    task automatic cyc(input logic [4:0] r, input logic l, input string tag,
                       input logic [4:0] eg, input logic [2:0] eid,
                       input logic eb, input logic et);
        exp_t e;
        req = r;
        rel = l;
        e.tag = tag; e.gnt = eg; e.id = eid; e.busy = eb; e.tmo = et;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed gnt %0h", tag, gnt);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
            chk({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
            chk({e.tag, ".timeout"}, 32'(timeout), 32'(e.tmo));
            if (e.busy) chk({e.tag, ".gnt_id"}, 32'(gnt_id), 32'(e.id));
        end
    endtask

    task automatic g(input logic [4:0] r, input logic l, input logic [2:0] owner, input string tag);
        cyc(r, l, tag, 5'b00001 << owner, owner, 1'b1, 1'b0);
    endtask

    task automatic d(input logic [4:0] r, input logic l, input string tag);
        cyc(r, l, tag, 5'b00000, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".gnt"}, 32'(gnt), 32'd0);
        chk({tag, ".gnt_id"}, 32'(gnt_id), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".timeout"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 5'b00000;
        rel   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Fairness from ptr=0: owners 0,1,2,3,4,0, rel two cycles after each grant.
        for (int k = 0; k < 6; k++) begin
            g(5'b11111, 1'b0, 3'(k % 5), $sformatf("fair%0d_g", k));
            g(5'b11111, 1'b0, 3'(k % 5), $sformatf("fair%0d_hold", k));
            d(5'b11111, 1'b1, $sformatf("fair%0d_gap", k));
            d(5'b11111, 1'b0, $sformatf("fair%0d_idle", k));
        end

        // ptr is 1; owner 3 then release leaves ptr at 4.
        g(5'b01000, 1'b0, 3'd3, "wrap_own3");
        d(5'b01000, 1'b1, "wrap_gap3");
        d(5'b00000, 1'b0, "wrap_idle3");
        // ptr=4 with req=00011: 0 wins, a non-owner req drop changes nothing, then 1.
        g(5'b00011, 1'b0, 3'd0, "wrap_own0");
        g(5'b00001, 1'b0, 3'd0, "wrap_req1_drop");
        g(5'b00011, 1'b0, 3'd0, "wrap_req1_back");
        d(5'b00011, 1'b1, "wrap_gap0");
        d(5'b00011, 1'b0, "wrap_idle0");
        g(5'b00011, 1'b0, 3'd1, "wrap_own1");
        d(5'b00000, 1'b0, "wrap_drop1");
        d(5'b00000, 1'b0, "wrap_idle1");
        // Only requester 4: owner 4, then ptr wraps to 0.
        g(5'b10000, 1'b0, 3'd4, "wrap_own4");
        d(5'b10000, 1'b1, "wrap_gap4");
        d(5'b00000, 1'b0, "wrap_idle4");
        g(5'b11111, 1'b0, 3'd0, "wrap_ptr0");
        d(5'b00000, 1'b0, "wrap_drop0");
        d(5'b00000, 1'b1, "rel_in_idle");

        // Single requester 2: grant four cycles, rel, dead cycles, regrant.
        for (int k = 1; k <= 4; k++) g(5'b00100, 1'b0, 3'd2, $sformatf("single_c%0d", k));
        d(5'b00100, 1'b1, "single_gap");
        d(5'b00100, 1'b0, "single_idle");
        g(5'b00100, 1'b0, 3'd2, "single_regrant");
        d(5'b00000, 1'b0, "single_drop");
        d(5'b00000, 1'b0, "single_idle2");

`ifdef RR5_ARBITER_TIMEOUT_EN
        for (int k = 0; k < 8; k++) g(5'b00001, 1'b0, 3'd0, $sformatf("tmo_hold%0d", k));
        cyc(5'b00001, 1'b0, "tmo_pulse", 5'b00000, 3'd0, 1'b0, 1'b1);
        cyc(5'b00001, 1'b0, "tmo_idle", 5'b00000, 3'd0, 1'b0, 1'b0);
        g(5'b00001, 1'b0, 3'd0, "tmo_regrant");
`else
        for (int k = 0; k < 110; k++) g(5'b00001, 1'b0, 3'd0, $sformatf("notmo_hold%0d", k));
`endif
        d(5'b00000, 1'b0, "tmo_drop");
        d(5'b00000, 1'b0, "tmo_idle2");

        // Mid-grant reset while owner=3.
        g(5'b01000, 1'b0, 3'd3, "mrst_own3");
        g(5'b01000, 1'b0, 3'd3, "mrst_hold3");
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mrst_async");
        req = 5'b01001;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("mrst_held");
        rst_n = 1'b1;
        g(5'b01001, 1'b0, 3'd0, "mrst_first_own0");
        d(5'b01001, 1'b1, "mrst_gap");

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr5_arbiter.md
RR5_ARBITER -- requirements
Module: rr5_arbiter

Interface
REQ-001 Parameter N, default 5: number of requesters; round-robin pointer is a mod-N counter.
REQ-002 Parameter MAX_HOLD, default 8: maximum grant length in cycles when timeout is compiled in.
REQ-003 Parameter IDW, default 3: width of gnt_id and pointer, SHALL satisfy 2**IDW >= N.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  N  per-requester request level; bit i high = requester i wants the resource.
REQ-007 rel  input  1  release pulse from the current owner; ignored outside GRANT.
REQ-008 gnt  output  N  one-hot grant, registered; all-zero when no owner.
REQ-009 gnt_id  output  IDW  index of current owner, valid only while busy=1.
REQ-010 busy  output  1  high while in GRANT.
REQ-011 timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-012 FSM states SHALL be IDLE, GRANT and GAP; reset state is IDLE.
REQ-013 IDLE: if req != 0, the next state is GRANT, and gnt/gnt_id are loaded with the winner on that same edge; otherwise the FSM stays in IDLE.
REQ-014 Winner SHALL be the first set req bit searching ptr, ptr+1, ... wrapping N-1 -> 0.
REQ-015 Latency: req high at edge k while in IDLE -> gnt visible from edge k to k+1, i.e. one cycle.
REQ-016 GRANT: gnt SHALL hold stable until rel=1, req[owner]=0, or a timeout; on any of these the next state is GAP.
REQ-017 On leaving GRANT, ptr SHALL become (owner+1) mod N; owner N-1 wraps ptr to 0.
REQ-018 GAP lasts exactly one cycle with gnt=0 and busy=0, then returns to IDLE; back-to-back grants are separated by at least one dead cycle.
REQ-019 A rel asserted together with a new req from another requester SHALL NOT shorten GAP.
REQ-020 A requester whose req falls while another requester owns the resource loses nothing; it is re-evaluated in the next IDLE.
REQ-021 gnt SHALL never have more than one bit set, and no grant SHALL be issued to a requester whose req=0.
REQ-022 Hold counter SHALL clear on entry to GRANT and increment each GRANT cycle, saturating at MAX_HOLD-1.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, ptr=0, hold counter=0, gnt=0, gnt_id=0, busy=0, timeout=0, independent of clk.
REQ-024 Reset during GRANT SHALL drop gnt asynchronously with no GAP cycle; the first post-reset grant searches from index 0.
REQ-025 Reset release is synchronous-deasserted by the system; the first arbitration occurs on the first rising edge after rst_n is high.

Configuration
REQ-026 Macro RR5_ARBITER_TIMEOUT_EN defined: in GRANT with hold counter = MAX_HOLD-1 and neither rel nor req drop, the next state SHALL be GAP, timeout SHALL pulse for one cycle aligned with the first GAP cycle, and ptr SHALL advance as in REQ-017.
REQ-027 Macro undefined: no hold counter is built, grants last until rel or req drop, and timeout is tied to 0.

Structure
REQ-028 Shared package arb_pkg SHALL hold the state encoding (IDLE=2'b00, GRANT=2'b01, GAP=2'b10) and the default N/IDW constants.
REQ-029 The pointer SHALL be a sub-module rr_mod_ptr: a mod-N counter with load enable, async active-low reset to 0, and an output of the current value.
REQ-030 An unreachable state encoding SHALL recover to IDLE with gnt=0 on the next edge.

Verification
REQ-031 Single requester: req=5'b00100 from reset, rel at cycle 4 -> gnt=00100 and gnt_id=2 from cycle 1 to 4, gnt=0 in GAP, regrant at cycle 7 if req is still high.
REQ-032 Fairness: req=11111 held, rel pulsed two cycles after each grant -> owners 0,1,2,3,4,0 in order, one dead cycle between grants.
REQ-033 Wrap: ptr=4 with req=00011 -> owner 0, then owner 1; with req=10000 only -> owner 4, then ptr=0.
REQ-034 Timeout (macro on, MAX_HOLD=8): req=00001 with no rel -> gnt high for exactly 8 cycles, timeout pulse on the first GAP cycle; macro off -> gnt held for more than 100 cycles and timeout=0.
REQ-035 Mid-grant reset: rst_n low for 2 cycles while owner=3 -> gnt=0 immediately; after release with req=01001, owner is 0.
